// File: rtl/dmem_dma_pkg.sv
// Shared types and default widths for the dmem block-copy engine.
package dmem_dma_pkg;

    // Engine states; IDLE/FIN bracket every transfer, READ/WRITE move one word.
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StFin
    } dma_state_e;

    localparam int unsigned DMEM_DEPTH = 256;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 9;

endpackage

// File: rtl/dmem_dma_ctr.sv
// Loadable down-counter with zero flag; tracks the remaining word count.
module dmem_dma_ctr #(
    parameter int unsigned W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/dmem_dma.sv
// Block-copy initiator driving the master side of the 256x16 dmem port.
// Optional build macro DMA_FILL_EN adds a fill mode that writes a constant
// value to consecutive destination words without reading.
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
`ifdef DMA_FILL_EN
    input  logic              fill_mode_i,
    input  logic [DATA_W-1:0] fill_value_i,
`endif
    input  logic              mem_grant_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  words_left_o
);

    dma_state_e        state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
`ifdef DMA_FILL_EN
    logic              fill_q;
`endif

    logic             ctr_load;
    logic             ctr_dec;
    logic             ctr_zero;
    logic [LEN_W-1:0] words_left;
    logic             last_word;

    assign ctr_load  = (state_q == StIdle) && start_i && (len_i != '0);
    assign ctr_dec   = (state_q == StWrite) && mem_grant_i;
    // Zero term is defensive only; a WRITE is never entered with an empty count.
    assign last_word = (words_left == LEN_W'(1)) || ctr_zero;

    dmem_dma_ctr #(
        .W (LEN_W)
    ) u_ctr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (ctr_load),
        .load_val_i (len_i),
        .dec_i      (ctr_dec),
        .count_o    (words_left),
        .zero_o     (ctr_zero)
    );

    // Transfer FSM with pointers, read latch and registered busy/done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            src_q   <= src_addr_i;
                            dst_q   <= dst_addr_i;
                            busy_q  <= 1'b1;
                            state_q <= StRead;
`ifdef DMA_FILL_EN
                            fill_q  <= fill_mode_i;
                            // Fill reuses the read latch as the constant source.
                            if (fill_mode_i) begin
                                data_q  <= fill_value_i;
                                state_q <= StWrite;
                            end
`endif
                        end else begin
                            // Empty transfer: no memory access, just the done pulse.
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (mem_grant_i) begin
                        data_q  <= mem_rdata_i;
                        src_q   <= src_q + 1'b1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (mem_grant_i) begin
                        dst_q <= dst_q + 1'b1;
                        if (last_word) begin
                            state_q <= StFin;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
`ifdef DMA_FILL_EN
                            state_q <= fill_q ? StWrite : StRead;
`else
                            state_q <= StRead;
`endif
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memory strobes follow state and grant directly; bus is zero when idle.
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_grant_i && (state_q == StRead)) begin
            mem_read_o = 1'b1;
            mem_addr_o = src_q;
        end else if (mem_grant_i && (state_q == StWrite)) begin
            mem_write_o = 1'b1;
            mem_addr_o  = dst_q;
            mem_wdata_o = data_q;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign words_left_o = words_left;

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: a 256x16 memory model on the port and a
// word-level reference copy/fill model compared after every transfer.
module tb_dmem_dma;
    import dmem_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [8:0]  len;
    logic        grant;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [8:0]  words_left;
`ifdef DMA_FILL_EN
    logic        fill_mode;
    logic [15:0] fill_value;
`endif

    logic [15:0] mem     [DMEM_DEPTH];
    logic [15:0] ref_mem [DMEM_DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_dma u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .len_i        (len),
`ifdef DMA_FILL_EN
        .fill_mode_i  (fill_mode),
        .fill_value_i (fill_value),
`endif
        .mem_grant_i  (grant),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_write_o  (mem_write),
        .mem_read_o   (mem_read),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy),
        .done_o       (done),
        .words_left_o (words_left)
    );

    // dmem model: combinational read, write committed at the rising edge.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: ascending word copy with 8-bit address wrap.
    task automatic model_copy(input int src, input int dst, input int n);
        for (int i = 0; i < n; i++) ref_mem[(dst + i) % 256] = ref_mem[(src + i) % 256];
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_eq(tag, bad, 0);
    endtask

    // gmode: 100 = grant always, 200 = two low cycles then one high, else % chance.
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [8:0] n,
                            input int gmode, input bit restart,
                            output int cyc, output int busy_cyc, output int n_wr,
                            output int n_rd, output int viol, output bit got_done);
        cyc = 0; busy_cyc = 0; n_wr = 0; n_rd = 0; viol = 0; got_done = 1'b0;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 2000; k++) begin
            cyc = k;
            if (gmode == 100)      grant = 1'b1;
            else if (gmode == 200) grant = (k % 3 == 0);
            else                   grant = ($urandom_range(99) < gmode);
            #1;
            if (busy) busy_cyc++;
            if (mem_write) n_wr++;
            if (mem_read) n_rd++;
            if ((mem_read || mem_write) && !grant) viol++;
            if (mem_read && mem_write) viol++;
            if (!mem_read && !mem_write && (mem_addr != 0 || mem_wdata != 0)) viol++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (restart && k == 3) begin
                src_addr = 16'h0000; dst_addr = 16'h0090; len = 9'd9; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("done_seen", got_done, 1'b1);
        @(negedge clk);
        grant = 1'b0;
    endtask

    int  cyc, bcyc, nwr, nrd, viol;
    bit  gd;
    int  rs, rd, rn;

    initial begin
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; grant = 1'b0;
`ifdef DMA_FILL_EN
        fill_mode = 1'b0; fill_value = '0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[16'h10] = 16'h00A1; mem[16'h11] = 16'h00B2;
        mem[16'h12] = 16'h00C3; mem[16'h13] = 16'h00D4;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_words_left", words_left, 0);
        check_eq("rst_strobes", {mem_read, mem_write}, 0);
        check_eq("rst_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4-word copy with grant held.
        model_copy(16'h10, 16'h40, 4);
        run_xfer(16'h0010, 16'h0040, 9'd4, 100, 1'b0, cyc, bcyc, nwr, nrd, viol, gd);
        check_eq("basic_latency", cyc, 9);
        check_eq("basic_busy_cycles", bcyc, 8);
        check_eq("basic_writes", nwr, 4);
        check_eq("basic_viol", viol, 0);
        check_eq("basic_w40", mem[16'h40], 16'h00A1);
        check_eq("basic_w43", mem[16'h43], 16'h00D4);
        check_eq("basic_words_left", words_left, 0);
        compare_mem("basic_mem");

        // Zero-length start.
        run_xfer(16'h0005, 16'h0006, 9'd0, 100, 1'b0, cyc, bcyc, nwr, nrd, viol, gd);
        check_eq("len0_latency", cyc, 1);
        check_eq("len0_busy", bcyc, 0);
        check_eq("len0_access", nwr + nrd, 0);
        compare_mem("len0_mem");

        // Grant dropped for two cycles ahead of every access.
        model_copy(16'h50, 16'h60, 3);
        run_xfer(16'h0050, 16'h0060, 9'd3, 200, 1'b0, cyc, bcyc, nwr, nrd, viol, gd);
        check_eq("stall_latency", cyc, 19);
        check_eq("stall_writes", nwr, 3);
        check_eq("stall_reads", nrd, 3);
        check_eq("stall_viol", viol, 0);
        compare_mem("stall_mem");

        // Source wraps past 0xFF; a second start mid-transfer is ignored.
        model_copy(16'hFE, 16'h20, 4);
        run_xfer(16'h00FE, 16'h0020, 9'd4, 100, 1'b1, cyc, bcyc, nwr, nrd, viol, gd);
        check_eq("wrap_latency", cyc, 9);
        check_eq("wrap_writes", nwr, 4);
        compare_mem("wrap_mem");

        // Reset after two words of an eight-word copy.
        @(negedge clk);
        src_addr = 16'h0030; dst_addr = 16'h00C0; len = 9'd8; start = 1'b1; grant = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_strobes", {mem_read, mem_write}, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_words_left", words_left, 0);
        check_eq("abort_bus", {mem_addr, mem_wdata}, 0);
        gd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
        end
        check_eq("abort_no_done", gd, 0);
        rst_n = 1'b1;
        grant = 1'b0;
        model_copy(16'h30, 16'hC0, 2);
        compare_mem("abort_mem");

`ifdef DMA_FILL_EN
        fill_mode = 1'b1; fill_value = 16'hBEEF;
        for (int i = 0; i < 5; i++) ref_mem[16'h80 + i] = 16'hBEEF;
        run_xfer(16'h0011, 16'h0080, 9'd5, 100, 1'b0, cyc, bcyc, nwr, nrd, viol, gd);
        check_eq("fill_latency", cyc, 6);
        check_eq("fill_reads", nrd, 0);
        check_eq("fill_writes", nwr, 5);
        compare_mem("fill_mem");
        fill_mode = 1'b0;
`endif

        // Random transfers, including overlapping regions and random grant.
        for (int t = 0; t < 8; t++) begin
            rs = int'($urandom_range(255));
            rd = (t % 2 == 0) ? (rs + int'($urandom_range(5)) + 1) % 256
                              : int'($urandom_range(255));
            rn = int'($urandom_range(24, 1));
            model_copy(rs, rd, rn);
            run_xfer(16'(rs), 16'(rd), 9'(rn), (t < 2) ? 100 : 60, 1'b0,
                     cyc, bcyc, nwr, nrd, viol, gd);
            if (t < 2) check_eq("rand_latency", cyc, 2 * rn + 1);
            check_eq("rand_writes", nwr, rn);
            check_eq("rand_reads", nrd, rn);
            check_eq("rand_viol", viol, 0);
            check_eq("rand_words_left", words_left, 0);
            compare_mem("rand_mem");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Block-copy initiator for the 256x16 data memory: the master side of the dmem port (addr, write_data, mem_write, mem_read, read_data).
- The CPU programs source, destination and length, then pulses start. The engine moves words one at a time (read, then write) while it holds the memory grant.
- Sits beside the CPU load/store path; a top-level mux gives dmem to the engine while mem_grant is high.

Parameters:
- ADDR_W, 16, address width driven on mem_addr (dmem decodes [7:0] only).
- DATA_W, 16, data word width.
- LEN_W, 9, length field width; 256 words maximum.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  ADDR_W  first source word address; captured on accepted start.
- dst_addr  input  ADDR_W  first destination word address; captured on accepted start.
- len  input  LEN_W  number of words; captured on accepted start.
- mem_grant  input  1  arbiter permits the engine to drive dmem this cycle.
- mem_addr  output  ADDR_W  dmem address.
- mem_wdata  output  DATA_W  dmem write data.
- mem_write  output  1  dmem write strobe; the write commits at that rising edge.
- mem_read  output  1  dmem read enable; the read is combinational.
- mem_rdata  input  DATA_W  dmem read data, valid in the same cycle as mem_read.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the transfer completes.
- words_left  output  LEN_W  remaining word count.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; internal pointers, count and data latch 0.
- FSM states are IDLE, READ, WRITE and FIN.
- IDLE:
  - start=1 with len!=0: latch src, dst, len; go to READ; busy=1 from the next cycle.
  - start=1 with len==0: go to FIN directly. No memory access occurs.
- READ:
  - If mem_grant=1: mem_read=1, mem_addr=src_ptr. The latch captures mem_rdata at the edge, src_ptr+1, go to WRITE.
  - If mem_grant=0: mem_read=0, hold state.
- WRITE:
  - If mem_grant=1: mem_write=1, mem_addr=dst_ptr, mem_wdata=latch. At the edge: dst_ptr+1, words_left-1.
  - If words_left was 1, go to FIN; otherwise go to READ.
  - If mem_grant=0: hold state; the strobe stays low.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, go to IDLE.
- Strobes: mem_read and mem_write are combinational from state and mem_grant. They are never both high. Both are 0 in IDLE and FIN.
- mem_addr, mem_wdata: drive 0 whenever neither strobe is asserted.
- Throughput: 2 granted cycles per word. Total latency for N words with grant held high is 2N+1 cycles from start to the done pulse.
- Pointer arithmetic: pointers wrap modulo 2^ADDR_W. Effective dmem wrap is at 256; no error flag.
- Overlap: the copy is always ascending. For overlapping regions with dst>src, the result is the defined forward-copy result (a source word overwritten earlier is re-read).
- start while busy: ignored; the latched parameters are unchanged.
- Grant dropped mid-word: the read latch is retained. When grant returns, the transfer resumes with no repeated read and no lost write.
- Reset mid-transfer: abort immediately. Words already written stay in dmem, and no done pulse is produced.

Optional Feature:
- DMA_FILL_EN: adds input fill_mode (1) and fill_value (DATA_W), both captured on start.
- With the macro and fill_mode=1: the READ state is skipped. The engine writes fill_value to N consecutive dst words at 1 granted cycle per word, and src_addr is ignored.
- Without the macro: the ports are absent and the block is copy-only.

Decomposition:
- Package dmem_dma_pkg holds:
  - state enum (IDLE, READ, WRITE, FIN);
  - DMEM_DEPTH=256;
  - default widths.
- Sub-module dmem_dma_ctr: a loadable down-counter with a zero flag, used for words_left.
- Pointers and the FSM stay in the top.

Test Plan:
- Preload dmem[0x10..0x13]={A1,B2,C3,D4}, src=0x10, dst=0x40, len=4, grant=1 -> dmem[0x40..0x43]={A1,B2,C3,D4}; done after 9 cycles; busy high for 8.
- len=0 start -> no strobes; done pulse 1 cycle after start; busy never high.
- len=3, toggle grant low 2 cycles during each READ and WRITE -> correct copy; strobes never high while grant=0; no duplicate writes.
- src=0xFE, dst=0x20, len=4 -> copies dmem[0xFE,0xFF,0x00,0x01] (wrap); start pulsed again mid-transfer is ignored.
- Assert rst_n low after 2 words of an 8-word copy -> outputs 0 asynchronously; only dst+0 and dst+1 written; no done.
- DMA_FILL_EN: fill_mode=1, fill_value=0xBEEF, dst=0x80, len=5 -> dmem[0x80..0x84]=0xBEEF; mem_read never asserted; done 6 cycles after start.
